// File: rtl/data_write_scheduler.sv
`default_nettype none
// ============================================================================
// data_write_scheduler : round-robin owner of the shared bit-serial writer
// Rev 1.0
// ============================================================================
module data_write_scheduler #(
  parameter int N_REQ          = 4,
  parameter int FRAME_W        = 40,
  parameter int GAP_CYCLES     = 200000,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     swiptAlive,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*FRAME_W-1:0] frame_in,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         err,
  output logic [FRAME_W-1:0]       data_stream,
  output logic                     write,
  input  logic                     wr_done,
  output logic                     busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         state_q,     state_d;
  logic [N_REQ-1:0]   grant_q,     grant_d;
  logic [N_REQ-1:0]   ack_q,       ack_d;
  logic [N_REQ-1:0]   err_q,       err_d;
  logic [FRAME_W-1:0] data_q,      data_d;
  logic               write_q,     write_d;
  logic [PTR_W-1:0]   owner_q,     owner_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [RTY_W-1:0]   retry_q,     retry_d;
  logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic               done_prev_q, done_prev_d;

  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic [FRAME_W-1:0] win_frame;
  logic [PTR_W-1:0]   next_ptr;
  logic               done_rise;

  // Scan from the farthest offset down so the nearest set request at/after rr_ptr wins
  always_comb begin
    cand    = '0;
    win_idx = rr_ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req[cand]) win_idx = cand;
    end
  end

  always_comb begin
    win_frame = frame_in[FRAME_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_frame = frame_in[i*FRAME_W +: FRAME_W];
    end
  end

  assign next_ptr  = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
  assign done_rise = wr_done & ~done_prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      retry_q     <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      data_q      <= data_d;
      write_q     <= write_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_q     <= retry_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = '0;
    data_d      = data_q;
    write_d     = write_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    retry_d     = retry_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    done_prev_d = done_prev_q;
    case (state_q)
      S_IDLE: begin
        if (swiptAlive && |req) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          data_d           = win_frame;
          retry_d          = '0;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        write_d     = 1'b1;
        to_cnt_d    = '0;
        // Pre-set history so a wr_done still high from the last frame is not a rise
        done_prev_d = 1'b1;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        done_prev_d = wr_done;
        if (!swiptAlive) begin
          write_d = 1'b0;
          state_d = S_HOLD;
        end else if (done_rise) begin
          write_d        = 1'b0;
          ack_d[owner_q] = 1'b1;
          grant_d        = '0;
          rr_ptr_d       = next_ptr;
          gap_cnt_d      = '0;
          state_d        = S_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          write_d        = 1'b0;
          err_d[owner_q] = 1'b1;
          grant_d        = '0;
          rr_ptr_d       = next_ptr;
          gap_cnt_d      = '0;
          state_d        = S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (swiptAlive) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d[owner_q] = 1'b1;
            grant_d        = '0;
            rr_ptr_d       = next_ptr;
            gap_cnt_d      = '0;
            state_d        = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant       = grant_q;
    ack         = ack_q;
    err         = err_q;
    data_stream = data_q;
    write       = write_q;
    busy        = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_data_write_scheduler.sv
`default_nettype none
// ============================================================================
// tb_data_write_scheduler : randomized scoreboard bench for data_write_scheduler
// Rev 1.0
// ============================================================================
module tb_data_write_scheduler;

  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         nrst;
  logic         swiptAlive;
  logic [3:0]   req;
  logic [159:0] frame_in;
  logic [39:0]  fr [4];
  logic [3:0]   grant, ack, err;
  logic [39:0]  data_stream;
  logic         write, wr_done, busy;

  typedef struct packed {
    logic [1:0]  owner;
    logic [39:0] frame;
    logic        is_err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_ptr = 0;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  assign frame_in = {fr[3], fr[2], fr[1], fr[0]};

  always #5 clk = ~clk;

  data_write_scheduler #(
    .N_REQ(4), .FRAME_W(40), .GAP_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .req(req), .frame_in(frame_in),
    .grant(grant), .ack(ack), .err(err), .data_stream(data_stream), .write(write),
    .wr_done(wr_done), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Round-robin reference: first requester at or after the pointer, wrapping
  function automatic int arb(input logic [3:0] r, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic randomize_frames();
    for (int i = 0; i < 4; i++) fr[i] = {8'($urandom), $urandom};
  endtask

  task automatic wait_grant();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (grant != 4'b0) ok = 1;
    end
    check("grant_arrives", {63'b0, ok}, 64'd1);
  endtask

  task automatic launch(input logic [3:0] rv, input bit is_err,
                        output int owner, output logic [39:0] f);
    req        = rv;
    swiptAlive = 1'b1;
    owner      = arb(rv, model_ptr);
    f          = fr[owner];
    sb.push_back('{owner: 2'(owner), frame: f, is_err: is_err});
    wait_grant();
    check("grant_onehot", {60'b0, grant}, 64'd1 << owner);
    check("no_write_in_load", {63'b0, write}, 64'd0);
    @(negedge clk);
    check("write_after_2clk", {63'b0, write}, 64'd1);
    check("data_stream_latched", {24'b0, data_stream}, {24'b0, f});
    model_ptr = (owner + 1) % 4;
  endtask

  task automatic writer(input int owner, input int drop_at, input int rise_at, input bit keep_high);
    bit early = 0;
    for (int c = 1; c <= rise_at; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) wr_done = 1'b0;
      if (write !== 1'b1) early = 1;
    end
    check("write_held_until_done", {63'b0, early}, 64'd0);
    wr_done = 1'b1;
    @(negedge clk);
    check("no_ack_before_rise_seen", {60'b0, ack}, 64'd0);
    @(negedge clk);
    check("write_drops_on_done", {63'b0, write}, 64'd0);
    check("ack_pulse", {60'b0, ack}, 64'd1 << owner);
    @(negedge clk);
    check("ack_one_cycle", {60'b0, ack}, 64'd0);
    if (!keep_high) wr_done = 1'b0;
  endtask

  task automatic expect_timeout(input int owner);
    bit early = 0;
    for (int c = 1; c < TIMEOUT; c++) begin
      @(posedge clk); #1;
      if (write !== 1'b1) early = 1;
    end
    check("write_held_before_timeout", {63'b0, early}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("timeout_write_low", {63'b0, write}, 64'd0);
    check("timeout_err", {60'b0, err}, 64'd1 << owner);
    @(negedge clk);
    check("err_one_cycle", {60'b0, err}, 64'd0);
  endtask

  task automatic drop_once(input int owner, input logic [39:0] f, input bit last);
    repeat (4) @(posedge clk);
    #1 swiptAlive = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_write_low", {63'b0, write}, 64'd0);
    check("hold_grant_kept", {60'b0, grant}, 64'd1 << owner);
    swiptAlive = 1'b1;
    @(negedge clk);
    if (last) begin
      check("retry_exhausted_err", {60'b0, err}, 64'd1 << owner);
      check("retry_exhausted_grant", {60'b0, grant}, 64'd0);
    end else begin
      check("resend_load_write_low", {63'b0, write}, 64'd0);
      @(negedge clk);
      check("resend_write", {63'b0, write}, 64'd1);
      check("resend_same_frame", {24'b0, data_stream}, {24'b0, f});
    end
  endtask

  // Response monitor: every ack/err pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1 && (ack != 4'b0 || err != 4'b0)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: ack=%0h err=%0h required=none", ack, err);
        end else begin
          e = sb.pop_front();
          check("resp_owner", {60'b0, ack | err}, 64'd1 << e.owner);
          check("resp_is_err", {63'b0, err != 4'b0}, {63'b0, e.is_err});
          check("resp_not_both", {63'b0, (ack != 4'b0) && (err != 4'b0)}, 64'd0);
          check("resp_frame", {24'b0, data_stream}, {24'b0, e.frame});
          check("resp_no_grant", {60'b0, grant}, 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ow;
    logic [39:0] f;
    int          mode, drops;
    bit          to, is_e;
    logic [3:0]  rv;

    nrst = 1'b0; swiptAlive = 1'b0; req = 4'b0; wr_done = 1'b0;
    for (int i = 0; i < 4; i++) fr[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", {60'b0, grant}, 64'd0);
    check("rst_ack_err", {56'b0, ack, err}, 64'd0);
    check("rst_data", {24'b0, data_stream}, 64'd0);
    check("rst_write_busy", {62'b0, write, busy}, 64'd0);
    nrst = 1'b1;

    req = 4'b1111;
    repeat (6) @(negedge clk);
    check("no_grant_without_link", {59'b0, grant, busy}, 64'd0);
    req = 4'b0;

    // Held full request vector: rotation 0,1,2,3,0
    randomize_frames();
    for (int i = 0; i < 5; i++) begin
      launch(4'b1111, 1'b0, ow, f);
      check("rr_order", ow, exp_order[i]);
      writer(ow, 0, 3, 1'b0);
    end

    // Single requester, slow writer, wr_done left high afterwards
    fr[1] = 40'hA5A5A5A5A5;
    launch(4'b0010, 1'b0, ow, f);
    req = 4'b0;
    check("t1_data", {24'b0, data_stream}, 64'hA5A5A5A5A5);
    writer(ow, 0, 50, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_busy_in_gap", {63'b0, busy}, 64'd1);
    @(negedge clk);
    check("t1_busy_low_after_gap", {63'b0, busy}, 64'd0);

    // Stale wr_done on entry must not complete the frame
    launch(4'b1000, 1'b0, ow, f);
    writer(ow, 5, 30, 1'b0);

    // Silent writer times out
    launch(4'b0001, 1'b1, ow, f);
    expect_timeout(ow);

    // Three link drops: two resends then abandon
    launch(4'b0100, 1'b1, ow, f);
    for (int d = 0; d < 3; d++) drop_once(ow, f, d == 2);

    // Randomized traffic
    for (int it = 0; it < 16; it++) begin
      randomize_frames();
      mode  = $urandom_range(0, 5);
      drops = (mode == 5) ? 3 : (mode == 4) ? $urandom_range(1, 2) : 0;
      to    = (mode == 3);
      is_e  = (drops == 3) || to;
      rv    = 4'($urandom_range(1, 15));
      launch(rv, is_e, ow, f);
      req = 4'($urandom_range(0, 15));
      randomize_frames();
      for (int d = 0; d < drops; d++) drop_once(ow, f, d == 2);
      if (drops < 3) begin
        if (to) expect_timeout(ow);
        else    writer(ow, 0, $urandom_range(1, 20), 1'b0);
      end
    end

    // Async reset mid-WRITE, then arbitration restarts from requester 0
    launch(4'b0001, 1'b0, ow, f);
    writer(ow, 0, 2, 1'b0);
    launch(4'b0100, 1'b0, ow, f);
    repeat (10) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check("async_rst_write", {63'b0, write}, 64'd0);
    check("async_rst_grant", {60'b0, grant}, 64'd0);
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    void'(sb.pop_back());
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    launch(4'b1111, 1'b0, ow, f);
    check("post_reset_rr_start", ow, 0);
    req = 4'b0;
    writer(ow, 0, 5, 1'b0);

    begin
      bit idle = 0;
      for (int i = 0; i < 50 && !idle; i++) begin
        @(negedge clk);
        if (!busy) idle = 1;
      end
      check("final_idle", {63'b0, idle}, 64'd1);
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
